wash_cycle_ctrl: RTL and testbench
==================================

// Module: wash_cycle_ctrl
// PURPOSE
//   Washing-machine cycle sequencer; downstream consumer of the minute timer.
//   Walks IDLE->FILL->WASH->RINSE->[WASH->RINSE]->SPIN->IDLE on coin insertion,
//   ending each phase when the timer's minute count reaches that phase's
//   duration. Drives the timer's enable and pause inputs; restarts the timer
//   at every phase boundary. Flags cycle completion to the panel logic.
// PARAMETERS
//   FILL_MIN   5'd2  fill phase length, minutes
//   WASH_MIN   5'd5  wash phase length, minutes
//   RINSE_MIN  5'd2  rinse phase length, minutes
//   SPIN_MIN   5'd1  spin phase length, minutes (single 10 min, double 17 min)
// PORTS
//   clk            in   1  system clock (same clock as the minute timer)
//   rst_n          in   1  asynchronous active-low reset
//   coin_in        in   1  level; coin present, start request
//   double_wash    in   1  level; extra WASH+RINSE pass, sampled at start only
//   timer_pause    in   1  level; user pause request, honoured in SPIN only
//   timer_minutes  in   5  elapsed minutes of the current phase, from the timer
//   timer_enable   out  1  registered; run/hold-count request to the timer
//   pause_flag     out  1  registered; freeze request to the timer
//   wash_done      out  1  registered; cycle complete, held until next start
//   cycle_state    out  3  registered; IDLE=0 FILL=1 WASH=2 RINSE=3 SPIN=4
// BEHAVIOUR
//   Reset (async, any state): cycle_state=IDLE, timer_enable=0, pause_flag=0,
//     wash_done=0, double latch=0, second-pass flag=0. Released to IDLE only.
//   IDLE: timer_enable=0. coin_in=1 at edge -> FILL next cycle, timer_enable=1,
//     wash_done cleared, double_wash latched, second-pass flag cleared.
//   Phase end: in FILL/WASH/RINSE/SPIN when timer_enable=1, pause_flag=0 and
//     timer_minutes >= phase duration (unsigned 5-bit compare) -> at that edge
//     state advances and timer_enable<=0 for exactly one cycle (restart
//     cycle, timer clears); next edge timer_enable<=1. Compare is ignored
//     while timer_enable=0 (stale count must not end the new phase).
//   Transitions: FILL->WASH; WASH->RINSE; RINSE->WASH if double latched and
//     second-pass=0 (set second-pass), else RINSE->SPIN; SPIN->IDLE with
//     wash_done<=1 and timer_enable<=0 (no re-enable in IDLE).
//   Pause: pause_flag<=timer_pause when next state is SPIN, else 0. In
//     FILL/WASH/RINSE timer_pause is ignored. While pause_flag=1 the state
//     holds, timer_enable stays 1, phase completion is suppressed; drop of
//     timer_pause resumes next cycle with the count preserved.
//   coin_in and double_wash are don't-care outside IDLE; a held coin_in in
//     IDLE after completion starts a new cycle immediately (wash_done 1 cycle).
//   SPIN->IDLE forces pause_flag<=0 even if timer_pause is held.
//   Latency: start 1 edge; phase end to new phase 1 edge; to new count 2 edges.
//   Illegal cycle_state encodings (5-7) recover to IDLE, outputs cleared.
// TESTING (bench drives timer_minutes via a behavioural minute-timer model)
//   Single: coin pulse, double_wash=0 -> states 1,2,3,4,0 lasting 2,5,2,1
//     min; wash_done=1 after 10 min; one timer_enable=0 cycle per boundary.
//   Double: double_wash=1 at coin -> 1,2,3,2,3,4,0; wash_done after 17 min;
//     toggling double_wash mid-cycle changes nothing.
//   Pause: timer_pause=1 during WASH -> pause_flag stays 0, WASH still 5 min;
//     timer_pause=1 at SPIN+30 s for 20 s -> pause_flag=1 one edge later,
//     state held, SPIN ends at 1 min of enabled count.
//   Stale count: hold timer_minutes=5'd2 across FILL->WASH restart cycle ->
//     WASH does not end before timer_minutes returns from 0 to 5.
//   Reset mid-RINSE (rst_n low 3 cycles) -> all outputs 0 asynchronously,
//     IDLE; coin_in after release starts a fresh FILL, second pass cleared.
//   Coin during SPIN and held through completion -> ignored in SPIN, new FILL
//     one edge after IDLE entry, wash_done high exactly one cycle.

Source files
------------

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine cycle sequencer driving the minute timer.
// Sequence: IDLE -> FILL -> WASH -> RINSE -> [WASH -> RINSE] -> SPIN -> IDLE.
// At every phase boundary timer_enable drops for one cycle so that the timer
// restarts its count before the next phase begins.
module wash_cycle_ctrl #(
  parameter logic [4:0] FILL_MIN  = 5'd2,
  parameter logic [4:0] WASH_MIN  = 5'd5,
  parameter logic [4:0] RINSE_MIN = 5'd2,
  parameter logic [4:0] SPIN_MIN  = 5'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_in,
  input  logic       double_wash,
  input  logic       timer_pause,
  input  logic [4:0] timer_minutes,
  output logic       timer_enable,
  output logic       pause_flag,
  output logic       wash_done,
  output logic [2:0] cycle_state
);

  localparam int unsigned ST_W  = 3;
  localparam int unsigned MIN_W = 5;

  typedef enum logic [ST_W-1:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_RINSE = 3'd3,
    S_SPIN  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               enable_q, enable_d;
  logic               pause_q, pause_d;
  logic               done_q, done_d;
  logic               double_q, double_d;
  logic               second_q, second_d;
  logic [MIN_W-1:0]   phase_dur_c;
  logic               phase_end_c;

  // Duration of the phase currently running
  always_comb begin
    phase_dur_c = '0;
    case (state_q)
      S_FILL:  phase_dur_c = FILL_MIN;
      S_WASH:  phase_dur_c = WASH_MIN;
      S_RINSE: phase_dur_c = RINSE_MIN;
      S_SPIN:  phase_dur_c = SPIN_MIN;
      default: phase_dur_c = '0;
    endcase
  end

  // A phase may only end on a live, unfrozen count; a stale count seen during
  // the restart cycle (enable low) is ignored
  assign phase_end_c = enable_q && !pause_q && (timer_minutes >= phase_dur_c);

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    enable_d = enable_q;
    pause_d  = 1'b0;
    done_d   = done_q;
    double_d = double_q;
    second_d = second_q;

    case (state_q)
      S_IDLE: begin
        enable_d = 1'b0;
        if (coin_in) begin
          state_d  = S_FILL;
          enable_d = 1'b1;
          done_d   = 1'b0;
          double_d = double_wash;
          second_d = 1'b0;
        end
      end

      S_FILL, S_WASH, S_RINSE, S_SPIN: begin
        if (!enable_q) begin
          // restart cycle is over: let the timer count again
          enable_d = 1'b1;
        end else if (phase_end_c) begin
          enable_d = 1'b0;
          case (state_q)
            S_FILL:  state_d = S_WASH;
            S_WASH:  state_d = S_RINSE;
            S_RINSE: begin
              if (double_q && !second_q) begin
                state_d  = S_WASH;
                second_d = 1'b1;
              end else begin
                state_d = S_SPIN;
              end
            end
            S_SPIN: begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end

      default: begin
        state_d  = S_IDLE;
        enable_d = 1'b0;
        done_d   = 1'b0;
        double_d = 1'b0;
        second_d = 1'b0;
      end
    endcase

    // The user pause is only honoured while spinning
    pause_d = (state_d == S_SPIN) ? timer_pause : 1'b0;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      enable_q <= 1'b0;
      pause_q  <= 1'b0;
      done_q   <= 1'b0;
      double_q <= 1'b0;
      second_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      pause_q  <= pause_d;
      done_q   <= done_d;
      double_q <= double_d;
      second_q <= second_d;
    end
  end

  assign timer_enable = enable_q;
  assign pause_flag   = pause_q;
  assign wash_done    = done_q;
  assign cycle_state  = state_q;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Scoreboard bench for wash_cycle_ctrl with a behavioural minute timer.
// A minute is M clock cycles. Every change of the output tuple
// {cycle_state, timer_enable, pause_flag, wash_done} is an event; the monitor
// pops the expected tuple and the expected number of clock edges since the
// previous event (0 = don't care).
module tb_wash_cycle_ctrl;

  localparam int unsigned M = 8;
  localparam logic [2:0] IDLE = 3'd0, FILL = 3'd1, WASH = 3'd2, RINSE = 3'd3, SPIN = 3'd4;

  // Edges between the enable-high event of a phase and its end
  localparam int D_FILL  = 2 * M + 1;
  localparam int D_WASH  = 5 * M + 1;
  localparam int D_RINSE = 2 * M + 1;
  localparam int D_SPIN  = 1 * M + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_in = 1'b0;
  logic       double_wash = 1'b0;
  logic       timer_pause = 1'b0;
  logic [4:0] timer_minutes;
  logic       timer_enable, pause_flag, wash_done;
  logic [2:0] cycle_state;

  logic [4:0]  t_min;
  int unsigned t_sub;
  logic        stale = 1'b0;

  typedef struct packed {
    logic [2:0] st;
    logic       en;
    logic       pf;
    logic       dn;
    logic [7:0] dwell;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   edge_cnt = 0;

  wash_cycle_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .coin_in       (coin_in),
    .double_wash   (double_wash),
    .timer_pause   (timer_pause),
    .timer_minutes (timer_minutes),
    .timer_enable  (timer_enable),
    .pause_flag    (pause_flag),
    .wash_done     (wash_done),
    .cycle_state   (cycle_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Minute timer model: clears while disabled, freezes while paused
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_min <= 5'd0;
      t_sub <= 0;
    end else if (!timer_enable) begin
      t_min <= 5'd0;
      t_sub <= 0;
    end else if (!pause_flag) begin
      if (t_sub == M - 1) begin
        t_sub <= 0;
        if (t_min != 5'd31) t_min <= t_min + 5'd1;
      end else begin
        t_sub <= t_sub + 1;
      end
    end
  end

  assign timer_minutes = stale ? 5'd2 : t_min;

  function automatic void push(input logic [2:0] s, input logic e, input logic p,
                               input logic d, input int dw);
    exp_t x;
    x.st = s; x.en = e; x.pf = p; x.dn = d; x.dwell = 8'(dw);
    sb.push_back(x);
  endfunction

  // Phase entry: restart cycle (enable low) then enable high one edge later
  function automatic void push_phase(input logic [2:0] s, input int prev_dwell);
    push(s, 1'b0, 1'b0, 1'b0, prev_dwell);
    push(s, 1'b1, 1'b0, 1'b0, 1);
  endfunction

  function automatic void push_single(input int first_dwell);
    push(FILL, 1'b1, 1'b0, 1'b0, first_dwell);
    push_phase(WASH, D_FILL);
    push_phase(RINSE, D_WASH);
    push_phase(SPIN, D_RINSE);
    push(IDLE, 1'b0, 1'b0, 1'b1, D_SPIN);
  endfunction

  function automatic void push_double_to_rinse2(input int first_dwell);
    push(FILL, 1'b1, 1'b0, 1'b0, first_dwell);
    push_phase(WASH, D_FILL);
    push_phase(RINSE, D_WASH);
    push_phase(WASH, D_RINSE);
    push_phase(RINSE, D_WASH);
  endfunction

  // Monitor: compare every output change against the scoreboard
  logic [5:0] cur_obs, prev_obs;
  int         last_edge, dw;
  exp_t       ex;
  initial begin
    prev_obs  = 6'h3f;
    last_edge = 0;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      cur_obs = {cycle_state, timer_enable, pause_flag, wash_done};
      if (cur_obs !== prev_obs) begin
        dw = edge_cnt - last_edge;
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event @%0t: state=%0d en=%0b pause=%0b done=%0b dwell=%0d, none expected",
                   $time, cur_obs[5:3], cur_obs[2], cur_obs[1], cur_obs[0], dw);
        end else begin
          ex = sb.pop_front();
          if (cur_obs !== {ex.st, ex.en, ex.pf, ex.dn} ||
              (ex.dwell != 8'd0 && dw != int'(ex.dwell))) begin
            n_err++;
            $display("FAIL event @%0t: got state=%0d en=%0b pause=%0b done=%0b dwell=%0d, expected state=%0d en=%0b pause=%0b done=%0b dwell=%0d",
                     $time, cur_obs[5:3], cur_obs[2], cur_obs[1], cur_obs[0], dw,
                     ex.st, ex.en, ex.pf, ex.dn, ex.dwell);
          end
        end
        prev_obs  = cur_obs;
        last_edge = edge_cnt;
      end
    end
  end

  task automatic wait_state(input logic [2:0] s);
    int n = 0;
    while (cycle_state !== s && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (cycle_state !== s) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_state: state=%0d, required %0d within 400 cycles", cycle_state, s);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    while (sb.size() != 0) begin
      ex = sb.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_event: not observed, expected state=%0d en=%0b pause=%0b done=%0b",
               ex.st, ex.en, ex.pf, ex.dn);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic coin_pulse(input logic dbl);
    @(negedge clk);
    coin_in     = 1'b1;
    double_wash = dbl;
    @(negedge clk);
    coin_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    push(IDLE, 1'b0, 1'b0, 1'b0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single cycle; pause ignored in WASH; late double_wash ignored
    push_single(0);
    coin_pulse(1'b0);
    wait_state(WASH);
    timer_pause = 1'b1;
    double_wash = 1'b1;
    wait_state(RINSE);
    timer_pause = 1'b0;
    drain();
    double_wash = 1'b0;

    // Double cycle; stale count held across FILL->WASH restart; toggling
    push_double_to_rinse2(0);
    push_phase(SPIN, D_RINSE);
    push(IDLE, 1'b0, 1'b0, 1'b1, D_SPIN);
    coin_pulse(1'b1);
    double_wash = 1'b0;
    begin
      int n = 0;
      while (t_min != 5'd2 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    stale = 1'b1;
    wait_state(WASH);
    repeat (3) @(negedge clk);
    stale = 1'b0;
    double_wash = 1'b1;
    wait_state(RINSE);
    double_wash = 1'b0;
    drain();

    // Pause during SPIN, then pause raised on the final SPIN edge
    push(FILL, 1'b1, 1'b0, 1'b0, 0);
    push_phase(WASH, D_FILL);
    push_phase(RINSE, D_WASH);
    push_phase(SPIN, D_RINSE);
    push(SPIN, 1'b1, 1'b1, 1'b0, 4);
    push(SPIN, 1'b1, 1'b0, 1'b0, 3);
    push(IDLE, 1'b0, 1'b0, 1'b1, 5);
    coin_pulse(1'b0);
    wait_state(SPIN);
    repeat (4) @(negedge clk);
    timer_pause = 1'b1;
    repeat (3) @(negedge clk);
    timer_pause = 1'b0;
    repeat (5) @(negedge clk);
    timer_pause = 1'b1;
    @(negedge clk);
    timer_pause = 1'b0;
    drain();

    // Coin inserted in SPIN and held through completion
    push_single(0);
    push_single(1);
    coin_pulse(1'b0);
    wait_state(SPIN);
    coin_in = 1'b1;
    wait_state(IDLE);
    wait_state(FILL);
    coin_in = 1'b0;
    drain();

    // Asynchronous reset in the second RINSE of a double cycle
    push_double_to_rinse2(0);
    push(IDLE, 1'b0, 1'b0, 1'b0, 3);
    coin_pulse(1'b1);
    double_wash = 1'b0;
    wait_state(RINSE);
    wait_state(WASH);
    wait_state(RINSE);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drain();

    // Fresh single cycle after reset
    push_single(0);
    coin_pulse(1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
